// File: rtl/xadc_drp_cmd_bridge.sv
// Host command bridge for the XADC DRP port.
// Parses 6-byte command frames (A5 CMD ADDR D_HI D_LO CHK) from an 8-bit
// AXIS byte stream, runs one DRP write or read, and returns a 4-byte
// response frame (5A STATUS R_HI R_LO) on an 8-bit AXIS byte stream.
// Only one command is in flight at a time; the input stream is stalled
// from the checksum check until the response has been fully sent.
module xadc_drp_cmd_bridge #(
   parameter int DRP_TIMEOUT   = 64,
   parameter int FRAME_TIMEOUT = 1_200_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [6:0]  drp_daddr,
   output logic        drp_den,
   output logic        drp_dwe,
   output logic [15:0] drp_di,
   input  logic [15:0] drp_do,
   input  logic        drp_drdy,
   output logic        busy
);

   localparam int DCW = $clog2(DRP_TIMEOUT + 1);
   localparam int FCW = $clog2(FRAME_TIMEOUT + 1);

   localparam logic [7:0] SOF_CMD    = 8'hA5;
   localparam logic [7:0] SOF_RESP   = 8'h5A;
   localparam logic [7:0] CMD_WR     = 8'h01;
   localparam logic [7:0] CMD_RD     = 8'h02;
   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_BAD_CHK = 8'h01;
   localparam logic [7:0] ST_BAD_CMD = 8'h02;
   localparam logic [7:0] ST_DRP_TO  = 8'h03;

   typedef enum logic [2:0] {
      S_SYNC,
      S_HDR,
      S_CHECK,
      S_DRP_REQ,
      S_DRP_WAIT,
      S_RESP
   } state_t;

   state_t          state_q, state_d;
   logic            alive_q;
   logic [2:0]      hdr_idx_q;
   logic [7:0]      cmd_q, addr_q, dhi_q, dlo_q, chk_q;
   logic [FCW-1:0]  idle_cnt_q;
   logic [DCW-1:0]  drp_cnt_q;
   logic [7:0]      status_q;
   logic [15:0]     rdata_q;
   logic [1:0]      resp_idx_q;

   logic s_hs, m_hs;
   logic err_chk, err_cmd;
   logic frame_to, drp_to;
   logic drp_active;

   assign s_hs       = s_axis_tvalid && s_axis_tready;
   assign m_hs       = m_axis_tvalid && m_axis_tready;
   assign err_chk    = (cmd_q ^ addr_q ^ dhi_q ^ dlo_q) != chk_q;
   assign err_cmd    = ((cmd_q != CMD_WR) && (cmd_q != CMD_RD)) || addr_q[7];
   assign frame_to   = idle_cnt_q == FCW'(FRAME_TIMEOUT - 1);
   assign drp_to     = drp_cnt_q == DCW'(DRP_TIMEOUT);
   assign drp_active = (state_q == S_DRP_REQ) || (state_q == S_DRP_WAIT);

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_SYNC;
      else        state_q <= state_d;
   end

   // Next-state decode.
   // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_SYNC:
            if (s_hs && s_axis_tdata == SOF_CMD) state_d = S_HDR;
         S_HDR:
            if (s_hs) begin
               if (hdr_idx_q == 3'd4) state_d = S_CHECK;
            end else if (frame_to) begin
               state_d = S_SYNC;
            end
         S_CHECK:
            state_d = (err_chk || err_cmd) ? S_RESP : S_DRP_REQ;
         S_DRP_REQ:
            state_d = S_DRP_WAIT;
         S_DRP_WAIT:
            if (drp_drdy || drp_to) state_d = S_RESP;
         S_RESP:
            if (m_hs && resp_idx_q == 2'd3) state_d = S_SYNC;
         default:
            state_d = S_SYNC;
      endcase
   end

   // Marks the first clock after reset release so tready stays low during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alive_q <= 1'b0;
      else        alive_q <= 1'b1;
   end

   // Header capture and inter-byte idle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_idx_q  <= '0;
         cmd_q      <= '0;
         addr_q     <= '0;
         dhi_q      <= '0;
         dlo_q      <= '0;
         chk_q      <= '0;
         idle_cnt_q <= '0;
      end else begin
         if (state_q == S_SYNC) hdr_idx_q <= '0;
         if (state_q == S_HDR && s_hs) begin
            hdr_idx_q <= hdr_idx_q + 3'd1;
            case (hdr_idx_q)
               3'd0:    cmd_q  <= s_axis_tdata;
               3'd1:    addr_q <= s_axis_tdata;
               3'd2:    dhi_q  <= s_axis_tdata;
               3'd3:    dlo_q  <= s_axis_tdata;
               default: chk_q  <= s_axis_tdata;
            endcase
         end
         if (state_q != S_HDR || s_hs) idle_cnt_q <= '0;
         else if (!frame_to)           idle_cnt_q <= idle_cnt_q + 1'b1;
      end
   end

   // Status, DRP wait counter, read data latch and response byte index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q   <= '0;
         drp_cnt_q  <= '0;
         rdata_q    <= '0;
         resp_idx_q <= '0;
      end else begin
         case (state_q)
            S_CHECK: begin
               rdata_q    <= '0;
               resp_idx_q <= '0;
               if (err_chk)      status_q <= ST_BAD_CHK;
               else if (err_cmd) status_q <= ST_BAD_CMD;
               else              status_q <= ST_OK;
            end
            S_DRP_REQ:
               drp_cnt_q <= DCW'(1);
            S_DRP_WAIT: begin
               if (drp_drdy) begin
                  if (cmd_q == CMD_RD) rdata_q <= drp_do;
               end else if (drp_to) begin
                  status_q <= ST_DRP_TO;
               end else begin
                  drp_cnt_q <= drp_cnt_q + 1'b1;
               end
            end
            S_RESP:
               if (m_hs) resp_idx_q <= resp_idx_q + 2'd1;
            default: ;
         endcase
      end
   end

   // Response byte mux; index only advances on a handshake so data holds under backpressure.
   always_comb begin
      m_axis_tdata = 8'h00;
      if (state_q == S_RESP) begin
         case (resp_idx_q)
            2'd0:    m_axis_tdata = SOF_RESP;
            2'd1:    m_axis_tdata = status_q;
            2'd2:    m_axis_tdata = rdata_q[15:8];
            default: m_axis_tdata = rdata_q[7:0];
         endcase
      end
   end

   // Stream and DRP handshake outputs decoded from the current state.
   always_comb begin
      s_axis_tready = alive_q && (state_q == S_SYNC || state_q == S_HDR);
      m_axis_tvalid = state_q == S_RESP;
      busy          = state_q != S_SYNC;
      drp_den       = state_q == S_DRP_REQ;
      drp_dwe       = drp_den && (cmd_q == CMD_WR);
      drp_daddr     = drp_active ? addr_q[6:0]    : 7'd0;
      drp_di        = drp_active ? {dhi_q, dlo_q} : 16'd0;
   end

endmodule

// File: tb/tb_xadc_drp_cmd_bridge.sv
// Self-checking bench for xadc_drp_cmd_bridge: drives command frames,
// models the XADC DRP responder, and compares DRP transactions and
// response bytes against expectation queues filled at stimulus time.
module tb_xadc_drp_cmd_bridge;

   localparam int DRP_TO   = 16;
   localparam int FRAME_TO = 40;

   typedef struct packed {
      logic [6:0]  addr;
      logic        dwe;
      logic [15:0] di;
   } drp_txn_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  s_axis_tdata = 8'h00;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic [6:0]  drp_daddr;
   logic        drp_den;
   logic        drp_dwe;
   logic [15:0] drp_di;
   logic [15:0] drp_do = 16'h0000;
   logic        drp_drdy;
   logic        rsp_drdy = 1'b0;
   logic        late_drdy = 1'b0;
   logic        busy;

   assign drp_drdy = rsp_drdy | late_drdy;

   xadc_drp_cmd_bridge #(
      .DRP_TIMEOUT   (DRP_TO),
      .FRAME_TIMEOUT (FRAME_TO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .drp_daddr     (drp_daddr),
      .drp_den       (drp_den),
      .drp_dwe       (drp_dwe),
      .drp_di        (drp_di),
      .drp_do        (drp_do),
      .drp_drdy      (drp_drdy),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   logic [7:0] exp_bytes[$];
   drp_txn_t   exp_drp[$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Response monitor: scoreboard pop on each m_axis handshake.
   logic prev_tvalid = 1'b0;
   int   resp_start_cyc = -1;
   always @(negedge clk) begin
      logic [7:0] e;
      if (m_axis_tvalid && !prev_tvalid) resp_start_cyc = cyc;
      prev_tvalid = m_axis_tvalid;
      if (m_axis_tvalid && m_axis_tready) begin
         if (exp_bytes.size() == 0) begin
            check("unexpected_resp_byte", 64'(exp_bytes.size()), 64'd1);
         end else begin
            e = exp_bytes.pop_front();
            check("resp_byte", 64'(m_axis_tdata), 64'(e));
         end
      end
   end

   // DRP monitor and responder model.
   int          drdy_delay = 0;
   logic [15:0] do_val = 16'h0000;
   int          den_count = 0;
   int          den_cyc = -1;
   int          drdy_cyc = -1;
   always @(negedge clk) begin
      drp_txn_t t;
      if (drp_den) begin
         den_count++;
         den_cyc = cyc;
         if (exp_drp.size() == 0) begin
            check("unexpected_den", 64'(exp_drp.size()), 64'd1);
         end else begin
            t = exp_drp.pop_front();
            check("drp_txn", 64'({drp_daddr, drp_dwe, drp_di}), 64'(t));
         end
         if (drdy_delay > 0) begin
            repeat (drdy_delay) @(posedge clk);
            #1;
            rsp_drdy = 1'b1;
            drp_do   = do_val;
            drdy_cyc = cyc;
            @(posedge clk);
            #1;
            rsp_drdy = 1'b0;
            drp_do   = 16'h0000;
         end
      end
   end

   int accept_cyc = -1;

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      while (!s_axis_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("s_accept_timeout", 64'(n), 64'd0);
      accept_cyc = cyc;
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_frame(input logic [47:0] f);
      for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8]);
   endtask

   task automatic push_resp(input logic [31:0] r);
      for (int i = 0; i < 4; i++) exp_bytes.push_back(r[31-8*i -: 8]);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_bytes.size() != 0 || busy) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check("idle_timeout", 64'(n), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic allow_handshakes(input int cnt);
      int n;
      for (int k = 0; k < cnt; k++) begin
         @(posedge clk);
         #1;
         m_axis_tready = 1'b1;
         n = 0;
         @(negedge clk);
         while (!m_axis_tvalid && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (n >= 200) check("m_valid_timeout", 64'(n), 64'd0);
         @(posedge clk);
         #1;
         m_axis_tready = 1'b0;
      end
   endtask

   function automatic logic [63:0] all_outputs();
      return 64'({s_axis_tready, m_axis_tdata, m_axis_tvalid, drp_daddr,
                  drp_den, drp_dwe, drp_di, busy});
   endfunction

   initial begin
      int den_before;
      int changes;
      int n;
      logic [7:0] held;

      // Reset state.
      #12;
      check("reset_outputs", all_outputs(), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("tready_before_edge", 64'(s_axis_tready), 64'd0);
      @(posedge clk);
      #1;
      check("tready_after_edge", 64'(s_axis_tready), 64'd1);
      check("busy_idle", 64'(busy), 64'd0);

      // Write with drdy three cycles after den.
      drdy_delay = 3;
      do_val     = 16'hDEAD;
      den_before = den_count;
      exp_drp.push_back('{addr: 7'h41, dwe: 1'b1, di: 16'h1234});
      push_resp(32'h5A00_0000);
      send_frame(48'hA5_01_41_12_34_66);
      wait_idle();
      check("wr_den_count", 64'(den_count - den_before), 64'd1);
      check("wr_den_latency", 64'(den_cyc - accept_cyc), 64'd2);
      check("wr_resp_latency", 64'(resp_start_cyc - drdy_cyc), 64'd1);

      // Read returning 0xABC0.
      drdy_delay = 2;
      do_val     = 16'hABC0;
      exp_drp.push_back('{addr: 7'h00, dwe: 1'b0, di: 16'h0000});
      push_resp(32'h5A00_ABC0);
      send_frame(48'hA5_02_00_00_00_02);
      wait_idle();
      check("rd_resp_latency", 64'(resp_start_cyc - drdy_cyc), 64'd1);

      // Error frames: no DRP access.
      drdy_delay = 1;
      den_before = den_count;
      push_resp(32'h5A01_0000);
      send_frame(48'hA5_01_41_12_34_00);
      wait_idle();
      check("err_resp_latency", 64'(resp_start_cyc - accept_cyc), 64'd2);
      push_resp(32'h5A02_0000);
      send_frame(48'hA5_07_00_00_00_07);
      wait_idle();
      push_resp(32'h5A02_0000);
      send_frame(48'hA5_01_80_00_00_81);
      wait_idle();
      push_resp(32'h5A01_0000);
      send_frame(48'hA5_07_00_00_00_00);
      wait_idle();
      check("err_no_den", 64'(den_count - den_before), 64'd0);

      // 0xA5 inside the header is data; write response carries no read data.
      drdy_delay = 1;
      do_val     = 16'hFFFF;
      exp_drp.push_back('{addr: 7'h10, dwe: 1'b1, di: 16'hA55A});
      push_resp(32'h5A00_0000);
      send_frame(48'hA5_01_10_A5_5A_EE);
      wait_idle();

      // Resync: partial frame dropped after the idle timeout.
      send_byte(8'hFF);
      send_byte(8'h00);
      send_byte(8'hA5);
      repeat (FRAME_TO + 5) @(posedge clk);
      #1;
      check("resync_busy", 64'(busy), 64'd0);
      drdy_delay = 4;
      do_val     = 16'h1357;
      exp_drp.push_back('{addr: 7'h03, dwe: 1'b0, di: 16'h0000});
      push_resp(32'h5A00_1357);
      send_frame(48'hA5_02_03_00_00_01);
      wait_idle();

      // DRP timeout, then a late drdy with no effect.
      drdy_delay = 0;
      exp_drp.push_back('{addr: 7'h05, dwe: 1'b0, di: 16'h0000});
      push_resp(32'h5A03_0000);
      send_frame(48'hA5_02_05_00_00_07);
      wait_idle();
      check("timeout_latency", 64'(resp_start_cyc - den_cyc), 64'(DRP_TO + 1));
      late_drdy = 1'b1;
      @(posedge clk);
      #1;
      late_drdy = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("late_drdy_quiet", 64'({busy, m_axis_tvalid}), 64'd0);

      // Backpressure: 10-cycle stall between response bytes 2 and 3.
      m_axis_tready = 1'b0;
      drdy_delay = 2;
      do_val     = 16'hBEEF;
      exp_drp.push_back('{addr: 7'h22, dwe: 1'b0, di: 16'h0000});
      push_resp(32'h5A00_BEEF);
      send_frame(48'hA5_02_22_00_00_20);
      allow_handshakes(2);
      @(negedge clk);
      held    = m_axis_tdata;
      changes = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (m_axis_tdata !== held || !m_axis_tvalid) changes++;
      end
      check("bp_tdata_stable", 64'(changes), 64'd0);
      check("bp_held_byte", 64'(held), 64'hBE);
      allow_handshakes(2);
      m_axis_tready = 1'b1;
      wait_idle();

      // Reset during DRP_WAIT drops the frame.
      drdy_delay = 0;
      den_before = den_count;
      exp_drp.push_back('{addr: 7'h33, dwe: 1'b0, di: 16'h0000});
      send_frame(48'hA5_02_33_00_00_31);
      n = 0;
      while (den_count == den_before && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_den_seen", 64'(den_count - den_before), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check("midframe_reset_outputs", all_outputs(), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_tready", 64'(s_axis_tready), 64'd1);
      drdy_delay = 1;
      do_val     = 16'h0F0F;
      exp_drp.push_back('{addr: 7'h7F, dwe: 1'b1, di: 16'h0001});
      push_resp(32'h5A00_0000);
      send_frame(48'hA5_01_7F_00_01_7F);
      wait_idle();

      check("resp_queue_drained", 64'(exp_bytes.size()), 64'd0);
      check("drp_queue_drained", 64'(exp_drp.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
